// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed combinationally when the operation launches and is
// held in shadow registers; HI/LO only take it when busy falls, so the
// pipeline sees the same latency a real iterative unit would have.
//
// State table
//   IDLE | waiting for a start; counter holds 0
//   RUN  | mult/div in flight; counter holds remaining busy cycles
//
// Ports
//   clk       in   1   sole clock, rising edge
//   reset     in   1   asynchronous, active-low
//   start     in   1   single-cycle launch request for op
//   op        in   3   000 mult, 001 multu, 010 div, 011 divu,
//                      100 mthi, 101 mtlo, others no-op
//   A         in   32  rs operand
//   B         in   32  rt operand
//   busy      out  1   high while mult/div in flight
//   md_stall  out  1   start | busy
//   HI        out  32  HI register
//   LO        out  32  LO register
// ---------------------------------------------------------------------------
module mul_div_unit #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = ($clog2(MAX_LAT + 1) < 4) ? 4 : $clog2(MAX_LAT + 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             state, next_state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        shadow_hi, shadow_lo;
    logic               commit;

    logic               is_md, is_signed_div;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        dividend, divisor, q_mag, r_mag, quot, rem;
    logic [31:0]        res_hi, res_lo;

    assign is_md = start && (op[2] == 1'b0);
    assign is_signed_div = (op == 3'b010);

    // Signed division is done on magnitudes so that 0x80000000 / -1 lands
    // on 0x80000000 naturally instead of relying on overflow behaviour.
    always_comb begin
        prod_s   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u   = {32'b0, A} * {32'b0, B};
        dividend = (is_signed_div && A[31]) ? (~A + 32'd1) : A;
        divisor  = (is_signed_div && B[31]) ? (~B + 32'd1) : B;
        if (B == 32'd0) begin
            divisor = 32'd1;
        end
        q_mag = dividend / divisor;
        r_mag = dividend % divisor;
        quot  = (is_signed_div && (A[31] ^ B[31])) ? (~q_mag + 32'd1) : q_mag;
        rem   = (is_signed_div && A[31]) ? (~r_mag + 32'd1) : r_mag;
        case (op[1:0])
            2'b00:   begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
            2'b01:   begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
            default: begin res_hi = rem;           res_lo = quot;         end
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (is_md) next_state = RUN;
            RUN:  if (cnt == CNT_W'(1)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            shadow_hi <= '0;
            shadow_lo <= '0;
            commit    <= 1'b0;
            HI        <= '0;
            LO        <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (is_md) begin
                        cnt       <= op[1] ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
                        shadow_hi <= res_hi;
                        shadow_lo <= res_lo;
                        // divide by zero still occupies the unit but writes nothing
                        commit    <= !(op[1] && (B == 32'd0));
                    end else if (start && op == 3'b100) begin
                        HI <= A;
                    end else if (start && op == 3'b101) begin
                        LO <= A;
                    end
                end
                RUN: begin
                    if (cnt == CNT_W'(1)) begin
                        cnt <= '0;
                        if (commit) begin
                            HI <= shadow_hi;
                            LO <= shadow_lo;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    assign busy     = (state == RUN);
    assign md_stall = start | busy;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A, B;
    logic        busy, md_stall;
    logic [31:0] HI, LO;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mul_div_unit #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .busy(busy), .md_stall(md_stall), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Architectural effect of one accepted operation on HI/LO.
    task automatic model_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        longint p;
        longint unsigned pu;
        sa = a;
        sb = b;
        case (o)
            3'd0: begin p = longint'(sa) * longint'(sb); m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd1: begin pu = {32'b0, a} * {32'b0, b}; m_hi = pu[63:32]; m_lo = pu[31:0]; end
            3'd2: if (b != 0) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = a;
                    m_hi = 0;
                end else begin
                    m_lo = sa / sb;
                    m_hi = sa % sb;
                end
            end
            3'd3: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit poke);
        logic [31:0] old_hi, old_lo;
        int n, exp_lat;
        bit long_op;
        old_hi  = m_hi;
        old_lo  = m_lo;
        long_op = (o <= 3'd3);
        exp_lat = o[1] ? DIV_LAT : MULT_LAT;
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        #1 check("md_stall_start", 32'(md_stall), 32'd1);
        model_op(o, a, b);
        @(negedge clk);
        start = 1'b0; A = $urandom; B = $urandom;
        if (long_op) begin
            n = 0;
            while (busy === 1'b1 && n < 40) begin
                n++;
                check("hi_hold", HI, old_hi);
                check("lo_hold", LO, old_lo);
                check("md_stall_busy", 32'(md_stall), 32'd1);
                if (poke && n == 3) begin
                    start = 1'b1;
                    op = 3'($urandom_range(0, 7));
                    A = $urandom;
                    B = $urandom;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
            end
            start = 1'b0;
            check("busy_len", n, exp_lat);
        end else begin
            check("busy_idle", 32'(busy), 32'd0);
        end
        check("hi", HI, m_hi);
        check("lo", LO, m_lo);
        #1 check("md_stall_idle", 32'(md_stall), 32'd0);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        reset = 1'b0; start = 1'b0; op = '0; A = '0; B = '0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        check("rst_md_stall", 32'(md_stall), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("mult_m2x3_hi", HI, 32'hFFFF_FFFF);
        check("mult_m2x3_lo", LO, 32'hFFFF_FFFA);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("multu_max_hi", HI, 32'hFFFF_FFFE);
        check("multu_max_lo", LO, 32'h0000_0001);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_m7_lo", LO, 32'hFFFF_FFFD);
        check("div_m7_hi", HI, 32'hFFFF_FFFF);
        run_op(3'd3, 32'd7, 32'd2, 1'b0);
        check("divu_7_lo", LO, 32'd3);
        check("divu_7_hi", HI, 32'd1);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_ovf_lo", LO, 32'h8000_0000);
        check("div_ovf_hi", HI, 32'd0);

        // back-to-back mthi / mtlo
        @(negedge clk);
        start = 1'b1; op = 3'd4; A = 32'h1234_5678;
        model_op(3'd4, 32'h1234_5678, 32'd0);
        @(negedge clk);
        check("mthi_busy", 32'(busy), 32'd0);
        check("mthi_hi", HI, 32'h1234_5678);
        op = 3'd5; A = 32'h9ABC_DEF0;
        model_op(3'd5, 32'h9ABC_DEF0, 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("mtlo_busy", 32'(busy), 32'd0);
        check("mtlo_hi", HI, 32'h1234_5678);
        check("mtlo_lo", LO, 32'h9ABC_DEF0);

        // divide by zero with a start poked mid-flight
        run_op(3'd4, 32'd5, 32'd0, 1'b0);
        run_op(3'd5, 32'd6, 32'd0, 1'b0);
        run_op(3'd2, 32'd1234, 32'd0, 1'b1);
        check("div0_hi", HI, 32'd5);
        check("div0_lo", LO, 32'd6);
        run_op(3'd6, 32'hDEAD_BEEF, 32'd1, 1'b0);
        run_op(3'd7, 32'hDEAD_BEEF, 32'd1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = $urandom_range(0, 50) - 25; rb = $urandom_range(1, 9); end
                3: rb = 32'($urandom_range(0, 9)) - 32'd5;
                default: ;
            endcase
            run_op(ro, ra, rb, 1'($urandom_range(0, 1)));
        end

        // reset during a multu
        run_op(3'd4, 32'h1111_1111, 32'd0, 1'b0);
        run_op(3'd5, 32'h2222_2222, 32'd0, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 3'd1; A = 32'hFFFF_0000; B = 32'h0001_2345;
        #1 check("rst_run_md_stall_start", 32'(md_stall), 32'd1);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_run_busy_pre", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_run_busy", 32'(busy), 32'd0);
        check("rst_run_hi", HI, 32'd0);
        check("rst_run_lo", LO, 32'd0);
        check("rst_run_md_stall", 32'(md_stall), 32'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset = 1'b1;
        repeat (MULT_LAT + 2) begin
            @(negedge clk);
            check("post_rst_busy", 32'(busy), 32'd0);
            check("post_rst_hi", HI, 32'd0);
            check("post_rst_lo", LO, 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1; op = 3'd4; A = 32'hCAFE_F00D;
        @(negedge clk);
        start = 1'b0;
        check("first_start_hi", HI, 32'hCAFE_F00D);
        check("first_start_lo", LO, 32'd0);
        check("first_start_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
